// File: rtl/mem_responder.sv
// Wait-state memory responder: one 16-bit word per access, completing WAIT cycles after the strobe is seen.
// Define MEM_ADDR_CHECK_EN to flag (and neutralise) accesses whose address exceeds the 2^ADDR_W word storage.
module mem_responder #(
    parameter int ADDR_W = 8,
    parameter int WAIT   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    output logic [15:0] Data_to_CPU,
    output logic        Mem_RDY,
    output logic        Mem_ERR
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] LAST_CNT = 4'(WAIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic               is_write_reg, is_write_next;
    logic               bad_reg, bad_next;
    logic [15:0]        dout_reg;

    logic [15:0]        mem [DEPTH];

    logic               start;
    logic               complete;
    logic               orig_strobe;
    logic [ADDR_W-1:0]  cpl_addr;
    logic               cpl_bad;
    logic               cpl_write;
    logic               mem_we;
    logic               load_rd;
    logic               addr_hi_nz;
    logic               addr_out_of_range;

    // Upper address bits only exist when the storage is narrower than the bus.
    generate
        if (ADDR_W < 16) begin : g_hi
            assign addr_hi_nz = |ADDR[15:ADDR_W];
        end else begin : g_nohi
            assign addr_hi_nz = 1'b0;
        end
    endgenerate

`ifdef MEM_ADDR_CHECK_EN
    assign addr_out_of_range = addr_hi_nz;
`else
    logic range_unused;
    assign range_unused      = addr_hi_nz;
    assign addr_out_of_range = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        addr_next     = addr_reg;
        is_write_next = is_write_reg;
        bad_next      = bad_reg;
        start         = 1'b0;
        complete      = 1'b0;
        cpl_addr      = addr_reg;
        cpl_bad       = bad_reg;
        cpl_write     = is_write_reg;
        orig_strobe   = is_write_reg ? Mem_WE : Mem_OE;

        case (state_reg)
            IDLE: begin
                if (Mem_WE || Mem_OE) begin
                    start         = 1'b1;
                    addr_next     = ADDR[ADDR_W-1:0];
                    is_write_next = Mem_WE;
                    bad_next      = addr_out_of_range;
                    cnt_next      = 4'd1;
                    // With a single wait state the access completes on the edge that accepts it.
                    if (WAIT == 1) begin
                        state_next = HOLD;
                        complete   = 1'b1;
                        cpl_addr   = ADDR[ADDR_W-1:0];
                        cpl_bad    = addr_out_of_range;
                        cpl_write  = Mem_WE;
                    end else begin
                        state_next = Mem_WE ? WRITE : READ;
                    end
                end
            end
            READ, WRITE: begin
                if (!orig_strobe) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt_reg == LAST_CNT) begin
                    state_next = HOLD;
                    complete   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            HOLD: begin
                if (!orig_strobe) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase

        mem_we  = complete && cpl_write && !cpl_bad;
        load_rd = complete && !cpl_write;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            addr_reg     <= '0;
            is_write_reg <= 1'b0;
            bad_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            is_write_reg <= is_write_next;
            bad_reg      <= bad_next;
        end
    end

    // Read data register: loaded only on a read completion, otherwise holds.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dout_reg <= 16'h0000;
        end else if (load_rd) begin
            dout_reg <= cpl_bad ? 16'h0000 : mem[cpl_addr];
        end
    end

    // Storage has no reset so it maps onto block RAM and survives Reset.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[cpl_addr] <= Data_from_CPU;
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    logic err_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            err_reg <= 1'b0;
        end else if (start && addr_out_of_range) begin
            err_reg <= 1'b1;
        end
    end

    assign Mem_ERR = err_reg;
`else
    assign Mem_ERR = 1'b0;
`endif

    assign Mem_RDY     = (state_reg == HOLD);
    assign Data_to_CPU = dout_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder: the driver predicts each access, a negedge monitor checks it.
module tb_mem_responder;

    localparam int ADDR_W = 8;
    localparam int WAIT   = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Mem_OE = 1'b0;
    logic        Mem_WE = 1'b0;
    logic [15:0] ADDR = 16'h0000;
    logic [15:0] Data_from_CPU = 16'h0000;
    logic [15:0] Data_to_CPU;
    logic        Mem_RDY;
    logic        Mem_ERR;

    mem_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Mem_OE        (Mem_OE),
        .Mem_WE        (Mem_WE),
        .ADDR          (ADDR),
        .Data_from_CPU (Data_from_CPU),
        .Data_to_CPU   (Data_to_CPU),
        .Mem_RDY       (Mem_RDY),
        .Mem_ERR       (Mem_ERR)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          rise;
        int          fall;
        bit          is_read;
        logic [15:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    bit          have_cur = 1'b0;
    bit          prev_rdy = 1'b0;
    logic [15:0] exp_dout = 16'h0000;
    logic        exp_err  = 1'b0;
    logic [15:0] ref_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic bit is_bad(input logic [15:0] a);
`ifdef MEM_ADDR_CHECK_EN
        return (a >> ADDR_W) != 16'h0000;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: pops an expectation whenever Mem_RDY rises, checks timing, held data and the error flag.
    always @(negedge Clk) begin
        if (Reset) begin
            have_cur = 1'b0;
            prev_rdy = 1'b0;
            exp_dout = 16'h0000;
        end else begin
            if (Mem_RDY && !prev_rdy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdy: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    cur = sb_q.pop_front();
                    have_cur = 1'b1;
                    check("rdy_rise_cycle", 16'(cyc), 16'(cur.rise));
                    if (cur.is_read) exp_dout = cur.data;
                end
            end else if (sb_q.size() > 0 && cyc > sb_q[0].rise) begin
                checks++;
                errors++;
                $display("FAIL rdy_missing: got 0 expected 1 at cycle %0d", sb_q[0].rise);
                void'(sb_q.pop_front());
            end
            if (!Mem_RDY && have_cur) begin
                check("rdy_fall_cycle", 16'(cyc), 16'(cur.fall));
                have_cur = 1'b0;
            end
            check("data_to_cpu", Data_to_CPU, exp_dout);
            check("mem_err", {15'd0, Mem_ERR}, {15'd0, exp_err});
            prev_rdy = Mem_RDY;
        end
    end

    // Called at posedge+1; the current interval becomes cycle 0 of the access.
    task automatic access(input bit wr, input bit both, input logic [15:0] a,
                          input logic [15:0] d, input int n, input int gap);
        int   c   = cyc;
        bit   bad = is_bad(a);
        exp_t e;
        ADDR          = a;
        Data_from_CPU = d;
        Mem_WE        = wr;
        Mem_OE        = !wr || both;
        if (n >= WAIT) begin
            e.rise    = c + WAIT;
            e.fall    = c + n + 1;
            e.is_read = !wr;
            e.data    = bad ? 16'h0000 : ref_mem[a[ADDR_W-1:0]];
            sb_q.push_back(e);
            if (wr && !bad) ref_mem[a[ADDR_W-1:0]] = d;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            if (i == 0 && bad) exp_err = 1'b1;
            if (i < n - 1) begin
                ADDR = 16'($urandom);
                if (wr) Mem_OE = 1'($urandom);
                else begin
                    Mem_WE        = 1'($urandom);
                    Data_from_CPU = 16'($urandom);
                end
            end
        end
        Mem_OE = 1'b0;
        Mem_WE = 1'b0;
        ADDR   = 16'($urandom);
        $display("access %s addr=%h data=%h len=%0d start=%0d %s", wr ? (both ? "WR+OE" : "WRITE") : "READ ",
                 a, wr ? d : e.data, n, c, (n >= WAIT) ? "complete" : "abort");
        repeat (gap) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic reset_mid_write(input logic [15:0] a, input logic [15:0] d);
        ADDR          = a;
        Data_from_CPU = d;
        Mem_WE        = 1'b1;
        Mem_OE        = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        check("reset_dout", Data_to_CPU, 16'h0000);
        check("reset_rdy", {15'd0, Mem_RDY}, 16'h0000);
        check("reset_err", {15'd0, Mem_ERR}, 16'h0000);
        exp_err = 1'b0;
        @(posedge Clk);
        #1;
        Reset  = 1'b0;
        Mem_WE = 1'b0;
        $display("access RESET mid-write addr=%h data=%h", a, d);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        check("por_dout", Data_to_CPU, 16'h0000);
        check("por_rdy", {15'd0, Mem_RDY}, 16'h0000);
        check("por_err", {15'd0, Mem_ERR}, 16'h0000);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        for (int a = 0; a < DEPTH; a++) begin
            access(1'b1, 1'b0, 16'(a), 16'(a * 16'h9E37) ^ 16'h5A5A, WAIT, 1);
        end
        access(1'b1, 1'b0, 16'h0010, 16'hBEEF, WAIT, 1);

        access(1'b0, 1'b0, 16'h0010, 16'h0000, 3, 1);
        access(1'b1, 1'b0, 16'h0020, 16'h1234, 3, 1);
        access(1'b0, 1'b0, 16'h0020, 16'h0000, 3, 1);
        access(1'b1, 1'b0, 16'h0030, 16'hFFFF, 1, 1);
        access(1'b0, 1'b0, 16'h0030, 16'h0000, 3, 1);
        access(1'b1, 1'b1, 16'h0040, 16'h00AA, 3, 1);
        access(1'b0, 1'b0, 16'h0040, 16'h0000, 3, 1);
        reset_mid_write(16'h0050, 16'hDEAD);
        access(1'b0, 1'b0, 16'h0050, 16'h0000, 3, 1);
        access(1'b1, 1'b0, 16'h0050, 16'h7777, WAIT, 1);
        access(1'b0, 1'b0, 16'h0050, 16'h0000, WAIT, 2);
        access(1'b0, 1'b0, 16'h0110, 16'h0000, 3, 1);
        access(1'b0, 1'b0, 16'h0011, 16'h0000, 3, 1);

        for (int k = 0; k < 250; k++) begin
            int          op = $urandom_range(0, 3);
            logic [15:0] a;
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
            access(op == 1 || op == 2, op == 2, a, 16'($urandom),
                   $urandom_range(1, WAIT + 3), $urandom_range(1, 3));
        end

        repeat (4) @(posedge Clk);
        #1;
        check("queue_drained", 16'(sb_q.size()), 16'd0);
        check("no_open_access", {15'd0, have_cur}, 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
